// File: rtl/timer_prog_sequencer.sv
// timer_prog_sequencer
//   Programs a two-counter timer through its 4-bit data (d) and 2-bit address (a) write bus
//   on behalf of two requesters. Requesters are arbitrated round-robin.
//   Each accepted command runs these steps, one per cycle:
//     1. write the control nibble {sel, mode, 1}
//     2. write divisor bits [3:0]
//     3. write divisor bits [7:4]
//     4. re-arm the selected counter's gate
//   The sequencer then waits for a rising edge on that counter's output, bounded by TIMEOUT.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   reqN_valid/ready          command handshake for requester N (N = 0, 1)
//   reqN_sel/mode/div         command fields for requester N
//   resp_valid/id/err         one-cycle completion pulse, owning requester, timeout flag
//   busy                      high whenever not idle
//   d, a, g0, g1              timer write bus and gate inputs (all registered)
//   out0, out1                timer outputs, synchronous to clk
module timer_prog_sequencer #(
  parameter int unsigned TIMEOUT = 1023,  // max wait cycles before error (>= 1)
  parameter int unsigned TO_W    = 10     // timeout counter width, must hold TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_sel,
  input  logic [1:0] req0_mode,
  input  logic [7:0] req0_div,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_sel,
  input  logic [1:0] req1_mode,
  input  logic [7:0] req1_div,
  output logic       resp_valid,
  output logic       resp_id,
  output logic       resp_err,
  output logic       busy,
  output logic [3:0] d,
  output logic [1:0] a,
  output logic       g0,
  output logic       g1,
  input  logic       out0,
  input  logic       out1
);

  typedef enum logic [2:0] {
    StIdle,
    StCtrl,
    StLo,
    StHi,
    StArm,
    StWait,
    StDone
  } state_e;

  localparam logic [1:0]      AddrCtrl = 2'd2;
  localparam logic [1:0]      AddrIdle = 2'd3;
  localparam logic [TO_W-1:0] CntMax   = TO_W'(TIMEOUT);

  state_e          state_q;
  logic            rr_q;     // requester favoured when both are valid
  logic            sel_q;
  logic [7:0]      div_q;
  logic            id_q;
  logic [TO_W-1:0] cnt_q;
  logic            prev_q;   // out[sel] sampled last cycle
  logic            hist_q;   // prev_q holds a real sample (cleared on arm)

  logic       grant0, grant1, accept;
  logic       acc_sel;
  logic [1:0] acc_mode;
  logic [7:0] acc_div;
  logic       out_sel, edge_det, timeout_hit;

  always_comb begin
    grant1     = req1_valid && (!req0_valid || rr_q);
    grant0     = req0_valid && !grant1;
    req0_ready = (state_q == StIdle) && grant0;
    req1_ready = (state_q == StIdle) && grant1;
    accept     = req0_ready || req1_ready;
    acc_sel    = grant1 ? req1_sel  : req0_sel;
    acc_mode   = grant1 ? req1_mode : req0_mode;
    acc_div    = grant1 ? req1_div  : req0_div;
    out_sel    = sel_q ? out1 : out0;
    // The first sample after arming only seeds the history; it can never be an edge.
    edge_det    = hist_q && out_sel && !prev_q;
    timeout_hit = (cnt_q == CntMax);
  end

  // Outputs are assigned on the transition into a state, so they are valid during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      sel_q      <= 1'b0;
      div_q      <= 8'h00;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= 1'b0;
      hist_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      d          <= 4'h0;
      a          <= AddrIdle;
      g0         <= 1'b0;
      g1         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StCtrl;
            sel_q   <= acc_sel;
            div_q   <= acc_div;
            id_q    <= grant1;
            rr_q    <= !grant1;
            busy    <= 1'b1;
            a       <= AddrCtrl;
            d       <= {acc_sel, acc_mode, 1'b1};
            if (acc_sel) g1 <= 1'b0;
            else         g0 <= 1'b0;
          end
        end
        StCtrl: begin
          state_q <= StLo;
          a       <= {1'b0, sel_q};
          d       <= div_q[3:0];
        end
        StLo: begin
          state_q <= StHi;
          d       <= div_q[7:4];
        end
        StHi: begin
          state_q <= StArm;
          a       <= AddrIdle;
          d       <= 4'h0;
          if (sel_q) g1 <= 1'b1;
          else       g0 <= 1'b1;
          cnt_q   <= '0;
          prev_q  <= 1'b0;
          hist_q  <= 1'b0;
        end
        StArm: begin
          state_q <= StWait;
        end
        StWait: begin
          prev_q <= out_sel;
          hist_q <= 1'b1;
          if (edge_det || timeout_hit) begin
            state_q    <= StDone;
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_err   <= !edge_det;  // an edge wins over a simultaneous timeout
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        StDone: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_prog_sequencer.sv
// tb_timer_prog_sequencer
//   Directed bench for timer_prog_sequencer. Inputs change 1 time unit after the rising
//   edge and outputs are sampled at the same point. TIMEOUT is reduced to keep runs short.
module tb_timer_prog_sequencer;

  localparam int unsigned TIMEOUT = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sel;
  logic [1:0] req0_mode;
  logic [7:0] req0_div;
  logic       req1_valid, req1_ready, req1_sel;
  logic [1:0] req1_mode;
  logic [7:0] req1_div;
  logic       resp_valid, resp_id, resp_err, busy;
  logic [3:0] d;
  logic [1:0] a;
  logic       g0, g1, out0, out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_prog_sequencer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_mode  (req0_mode),
    .req0_div   (req0_div),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_mode  (req1_mode),
    .req1_div   (req1_div),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy),
    .d          (d),
    .a          (a),
    .g0         (g0),
    .g1         (g1),
    .out0       (out0),
    .out1       (out1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command, confirm it is granted, and return in the CTRL cycle (T+1).
  task automatic issue(input bit r, input bit s, input logic [1:0] m, input logic [7:0] dv,
                       input string tag);
    if (r) begin
      req1_sel = s; req1_mode = m; req1_div = dv; req1_valid = 1'b1;
    end else begin
      req0_sel = s; req0_mode = m; req0_div = dv; req0_valid = 1'b1;
    end
    #1;
    chk(tag, r ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Advance until resp_valid is seen, bounded; returns in the DONE cycle.
  task automatic wait_resp(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 1);
  endtask

  initial begin
    bit   early;
    logic exp_ids [4];
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_sel = 1'b0; req0_mode = 2'd0; req0_div = 8'h00;
    req1_valid = 1'b0; req1_sel = 1'b0; req1_mode = 2'd0; req1_div = 8'h00;
    out0 = 1'b0; out1 = 1'b0;
    tick();
    tick();
    chk("rst_a", a, 3);
    chk("rst_d", d, 0);
    chk("rst_g0", g0, 0);
    chk("rst_g1", g1, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: req0 sel=0 mode=2 div=0x5A, out0 rises 3 cycles after ARM.
    issue(1'b0, 1'b0, 2'd2, 8'h5A, "t1_ready");
    chk("t1_ctrl_a", a, 2);
    chk("t1_ctrl_d", d, 4'h5);
    chk("t1_g0_low", g0, 0);
    chk("t1_busy", busy, 1);
    chk("t1_no_ready", req0_ready, 0);
    tick();
    chk("t1_lo_a", a, 0);
    chk("t1_lo_d", d, 4'hA);
    tick();
    chk("t1_hi_a", a, 0);
    chk("t1_hi_d", d, 4'h5);
    tick();
    chk("t1_arm_a", a, 3);
    chk("t1_arm_d", d, 0);
    chk("t1_arm_g0", g0, 1);
    tick();
    tick();
    chk("t1_wait_no_resp", resp_valid, 0);
    tick();
    out0 = 1'b1;
    tick();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_id", resp_id, 0);
    chk("t1_resp_err", resp_err, 0);
    out0 = 1'b0;
    tick();
    chk("t1_resp_pulse", resp_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_resp_err_hold", resp_err, 0);

    // 2: both valid after reset; grants go 0,1,0,1 (no edges, so each times out).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req0_sel = 1'b0; req0_mode = 2'd0; req0_div = 8'h11;
    req1_sel = 1'b1; req1_mode = 2'd3; req1_div = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t2_ready0", req0_ready, 1);
    chk("t2_ready1", req1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      wait_resp("t2_resp_timeout");
      chk("t2_id", resp_id, exp_ids[k]);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    tick();

    // 3: req1 sel=1 div=0x03, out1 stuck low -> error TIMEOUT+1 cycles after WAIT entry.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    issue(1'b1, 1'b1, 2'd1, 8'h03, "t3_ready");
    chk("t3_ctrl_a", a, 2);
    chk("t3_ctrl_d", d, 4'hB);
    tick();
    chk("t3_lo_a", a, 1);
    chk("t3_lo_d", d, 4'h3);
    tick();
    chk("t3_hi_d", d, 4'h0);
    tick();
    chk("t3_arm_g1", g1, 1);
    chk("t3_arm_g0", g0, 0);
    tick();
    early = resp_valid;
    repeat (TIMEOUT) begin
      tick();
      early |= resp_valid;
    end
    chk("t3_no_early_resp", {31'b0, early}, 0);
    tick();
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_resp_err", resp_err, 1);
    chk("t3_resp_id", resp_id, 1);
    tick();
    chk("t3_g1_after_err", g1, 1);
    chk("t3_busy", busy, 0);

    // 6: counter1 running, program counter0; g1 must not move.
    issue(1'b0, 1'b0, 2'd3, 8'h21, "t6_ready");
    chk("t6_g1_ctrl", g1, 1);
    tick();
    chk("t6_g1_lo", g1, 1);
    tick();
    tick();
    chk("t6_g0_arm", g0, 1);
    chk("t6_g1_arm", g1, 1);
    tick();
    tick();
    out0 = 1'b1;
    wait_resp("t6_resp_timeout");
    chk("t6_resp_err", resp_err, 0);
    chk("t6_g1_done", g1, 1);
    out0 = 1'b0;
    tick();

    // 4: out0 already high entering WAIT -> no false edge; then falls and rises.
    out0 = 1'b1;
    issue(1'b0, 1'b0, 2'd0, 8'h10, "t4_ready");
    repeat (4) tick();
    repeat (3) begin
      chk("t4_no_false_edge", resp_valid, 0);
      tick();
    end
    out0 = 1'b0;
    tick();
    out0 = 1'b1;
    tick();
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_resp_err", resp_err, 0);
    out0 = 1'b0;
    tick();

    // 5: reset during LO aborts the command, then a new one completes.
    issue(1'b0, 1'b0, 2'd1, 8'h77, "t5_ready");
    tick();
    chk("t5_lo_d", d, 4'h7);
    rst = 1'b1;
    #1;
    chk("t5_rst_a", a, 3);
    chk("t5_rst_d", d, 0);
    chk("t5_rst_g0", g0, 0);
    chk("t5_rst_g1", g1, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_resp", resp_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_post_resp", resp_valid, 0);
    issue(1'b1, 1'b0, 2'd2, 8'hC4, "t5_next_ready");
    chk("t5_next_ctrl_d", d, 4'h5);
    tick();
    chk("t5_next_lo", d, 4'h4);
    tick();
    chk("t5_next_hi", d, 4'hC);
    tick();
    chk("t5_next_g0", g0, 1);
    tick();
    tick();
    out0 = 1'b1;
    wait_resp("t5_next_timeout");
    chk("t5_next_id", resp_id, 1);
    chk("t5_next_err", resp_err, 0);
    out0 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
